// File: rtl/dispatcher_pkg.sv
// Shared types and defaults for the job dispatcher and its operand FIFO.
package dispatcher_pkg;

    localparam int W_DEF       = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2
    } state_t;

    // One extra pointer bit separates the full and empty cases.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/job_fifo.sv
// Operand FIFO: circular buffer; the pointer MSB distinguishes full from empty.
module job_fifo
    import dispatcher_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [W-1:0]  r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    // Flags come only from the pointer registers, so a same-cycle pop never frees a slot early.
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage and pointer update; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/job_dispatcher.sv
// Job dispatcher: queues operands, issues one job at a time to the control unit,
// captures the result and guards each job with a watchdog.
//
//   state | meaning
//   IDLE  | waiting for a queued operand, an idle control unit and a free output register
//   ISSUE | permit asserted for exactly one cycle, x already loaded
//   RUN   | waiting for feito; watchdog counts down, timeout drops the job
module job_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         permit,
    output logic [W-1:0] x,
    input  logic         bc_ready,
    input  logic         feito,
    input  logic [W-1:0] res,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LOAD = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_wd_cnt;
    logic [W-1:0]  r_x;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic          r_err;
    logic          w_push;
    logic          w_pop;
    logic          w_capture;
    logic          w_timeout;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [W-1:0]  w_head;

    assign in_ready  = ~w_fifo_full;
    assign w_push    = in_valid & ~w_fifo_full;
    assign permit    = (r_state == ISSUE);
    assign busy      = (r_state != IDLE);
    assign x         = r_x;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err       = r_err;

    job_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next state and job events; feito only matters in RUN and wins over the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_fifo_empty && bc_ready && !r_out_valid) begin
                    w_state_nxt = ISSUE;
                    w_pop       = 1'b1;
                end
            end
            ISSUE: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (feito) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wd_cnt == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Watchdog: loaded during ISSUE so it reaches zero on the TIMEOUT-th RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_wd_cnt <= WD_LOAD;
        end else if (r_state == RUN && r_wd_cnt != '0) begin
            r_wd_cnt <= r_wd_cnt - WD_ONE;
        end
    end

    // Operand held for the datapath; changes only when a job is popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
        end else if (w_pop) begin
            r_x <= w_head;
        end
    end

    // Result register; IDLE never issues while it is full, so capture cannot overwrite.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= res;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky timeout flag; dispatch keeps going after a dropped job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_job_dispatcher.sv
// Bench for job_dispatcher: behavioural control-unit model, queue-based reference
// model and a scoreboard monitor decoupled from stimulus.
module tb_job_dispatcher;

    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int CU_LAT  = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         permit;
    logic [W-1:0] x;
    logic         bc_ready = 1'b0;
    logic         feito = 1'b0;
    logic [W-1:0] res = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         err;

    job_dispatcher #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .permit    (permit),
        .x         (x),
        .bc_ready  (bc_ready),
        .feito     (feito),
        .res       (res),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] q_in[$];
    logic [W-1:0] q_exp[$];
    int           occ = 0;
    bit           exp_err = 0;
    logic [W-1:0] cur_op = '0;
    int           n_permit = 0;
    int           n_out = 0;
    int           permit_cyc = 0;
    bit           last_drop = 0;

    // stimulus knobs
    bit bc_en = 0;
    bit drop_next = 0;
    bit rand_drop = 0;
    bit spur_idle = 0;
    bit spur_issue = 0;
    int or_mode = 0;

    function automatic logic [W-1:0] cu_func(input logic [W-1:0] a);
        return a ^ 8'h7F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // control unit model: feito 7 cycles after permit, or never when the job is dropped
    initial begin
        int left;
        logic [W-1:0] cu_res;
        logic [W-1:0] op;
        left = 0;
        cu_res = '0;
        forever begin
            @(negedge clk);
            feito = 1'b0;
            res   = 8'hEE;
            if (!rst) begin
                left = 0;
            end else begin
                if (left > 0) begin
                    left--;
                    if (left == 0 && !last_drop) begin
                        feito = 1'b1;
                        res   = cu_res;
                    end
                end
                if (spur_idle) begin
                    feito = 1'b1;
                    spur_idle = 0;
                end
                if (permit) begin
                    n_permit++;
                    permit_cyc = cyc;
                    last_drop = drop_next || (rand_drop && $urandom_range(0, 5) == 0);
                    drop_next = 0;
                    if (q_in.size() == 0) begin
                        fail_msg("permit_without_queued_job");
                    end else begin
                        op = q_in.pop_front();
                        cur_op = op;
                        chk("x_at_permit", x, op);
                        if (last_drop) exp_err = 1;
                        else q_exp.push_back(cu_func(op));
                        cu_res = cu_func(op);
                    end
                    left = CU_LAT;
                    if (spur_issue) begin
                        feito = 1'b1;
                        spur_issue = 0;
                    end
                end
            end
            bc_ready = bc_en && (left == 0);
        end
    end

    // consumer ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = 1'b0;
                default: begin
                    out_ready = 1'b1;
                    or_mode = 2;
                end
            endcase
        end
    end

    // scoreboard monitor
    initial begin
        bit           pv_valid;
        bit           pv_acc;
        bit           pv_permit;
        bit           pv_busy;
        logic [W-1:0] pv_data;
        pv_valid = 0; pv_acc = 0; pv_permit = 0; pv_busy = 0; pv_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                occ = 0;
                q_in.delete();
                q_exp.delete();
                exp_err = 0;
                pv_valid = 0; pv_acc = 0; pv_permit = 0; pv_busy = 0;
            end else begin
                if (permit) occ--;
                chk("in_ready", in_ready, 32'(occ < DEPTH));
                if (in_valid && occ < DEPTH) begin
                    q_in.push_back(in_data);
                    occ++;
                end
                if (permit && pv_permit) fail_msg("permit_longer_than_one_cycle");
                if (busy && !permit) chk("x_hold", x, cur_op);
                if (out_valid && !pv_valid) begin
                    n_out++;
                    chk("result_latency", cyc - permit_cyc, 8);
                    if (q_exp.size() == 0) fail_msg("unexpected_result");
                    else chk("out_data", out_data, q_exp.pop_front());
                end
                if (pv_valid && !pv_acc) begin
                    chk("out_hold_valid", out_valid, 1);
                    chk("out_hold_data", out_data, pv_data);
                end
                if (!busy && pv_busy) chk("job_length", cyc - permit_cyc, last_drop ? 16 : 8);
                if (err) chk("err_cause", err, exp_err);
                pv_valid  = out_valid;
                pv_acc    = out_valid && out_ready;
                pv_data   = out_data;
                pv_permit = permit;
                pv_busy   = busy;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input int bound, output bit acc);
        acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < bound && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_ok(input logic [W-1:0] d);
        bit acc;
        send(d, 200, acc);
        if (!acc) fail_msg("send_not_accepted");
    endtask

    task automatic wait_sig(input int sel, input int bound, input string name, output int at);
        bit hit;
        hit = 0;
        at = -1;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0: hit = permit;
                1: hit = out_valid;
                default: hit = err;
            endcase
            if (hit) at = cyc;
        end
        if (!hit) fail_msg({name, " no event within bound"});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int bound);
        bit done;
        done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            #1;
            done = (occ == 0) && (q_in.size() == 0) && (q_exp.size() == 0) && !busy && !out_valid;
        end
        if (!done) fail_msg("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int c;
        int at;
        int at2;
        int n0;
        int np0;
        bit acc;

        // reset values
        #1 rst = 1'b0;
        #2;
        chk("rst_permit", permit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_x", x, 0);
        chk("rst_err", err, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // single job
        bc_en = 1;
        or_mode = 0;
        wait_cycles(2);
        send_ok(8'h2A);
        c = cyc;
        wait_sig(0, 20, "single_permit", at);
        chk("single_issue_latency", at - c, 1);
        chk("single_x", x, 8'h2A);
        wait_sig(1, 30, "single_result", at2);
        chk("single_result_latency", at2 - c, 9);
        chk("single_out_data", out_data, 8'h55);
        wait_drain(50);

        // fill and order
        bc_en = 0;
        wait_cycles(2);
        for (int d = 1; d <= 4; d++) send_ok(8'(d));
        send(8'h05, 6, acc);
        chk("fifth_refused", acc, 0);
        chk("in_ready_when_full", in_ready, 0);
        n0 = n_out;
        bc_en = 1;
        wait_drain(300);
        chk("fill_result_count", n_out - n0, 4);

        // output backpressure
        @(negedge clk);
        or_mode = 2;
        @(posedge clk);
        #1;
        np0 = n_permit;
        for (int d = 0; d < 4; d++) send_ok(8'(8'h81 + d));
        wait_sig(1, 60, "bp_first_result", at);
        wait_cycles(20);
        chk("bp_single_permit", n_permit - np0, 1);
        chk("bp_out_valid_held", out_valid, 1);
        @(negedge clk);
        or_mode = 3;
        wait_sig(0, 10, "bp_resume", at2);
        chk("bp_second_permit", n_permit - np0, 2);
        @(negedge clk);
        or_mode = 0;
        wait_drain(300);

        // spurious feito in IDLE and ISSUE
        n0 = n_out;
        spur_idle = 1;
        wait_cycles(3);
        chk("spur_idle_no_result", out_valid, 0);
        chk("spur_idle_not_busy", busy, 0);
        spur_issue = 1;
        send_ok(8'h33);
        wait_drain(100);
        chk("spur_result_count", n_out - n0, 1);
        chk("spur_out_data", out_data, 8'h4C);

        // watchdog timeout, then continued dispatch
        drop_next = 1;
        send_ok(8'h10);
        send_ok(8'h11);
        wait_sig(2, 60, "timeout_err", at);
        chk("timeout_cycles", at - permit_cyc, 16);
        wait_drain(100);
        chk("err_sticky", err, 1);
        chk("after_timeout_out_data", out_data, 8'h6E);

        // reset in RUN with two entries queued
        send_ok(8'h20);
        send_ok(8'h21);
        send_ok(8'h22);
        wait_sig(0, 20, "rst_test_permit", at);
        wait_cycles(2);
        #2 rst = 1'b0;
        #1;
        chk("arst_permit", permit, 0);
        chk("arst_busy", busy, 0);
        chk("arst_x", x, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_err", err, 0);
        chk("arst_in_ready", in_ready, 1);
        wait_cycles(2);
        rst = 1'b1;
        np0 = n_permit;
        wait_cycles(5);
        chk("post_rst_no_permit", n_permit - np0, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_in_ready", in_ready, 1);

        // randomized traffic
        rand_drop = 1;
        or_mode = 1;
        for (int i = 0; i < 40; i++) begin
            wait_cycles($urandom_range(0, 3));
            send_ok(8'($urandom_range(0, 255)));
        end
        wait_cycles(30);
        @(negedge clk);
        or_mode = 0;
        rand_drop = 0;
        wait_drain(1000);
        chk("final_err", err, exp_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
